// File: rtl/control_unit.sv
// rtl/control_unit.sv - Hardwired Mini SRC control sequencer (fetch, decode, execute steps)
//
// Purpose: steps through IDLE, F0-F3, E0-E5 and HALT, and decodes (state, ir, con_out)
// combinationally into every datapath enable, bus select, ALU opcode and RAM strobe.
// Optional feature macro: CU_MULDIV_EN (makes mul op 15 and div op 16 legal).
//
// Ports:
//   clock, clear (async active-high), run     - sequencing inputs
//   ir[31:0], con_out                         - datapath status
//   e_* / incPC / ram_* / MDR_read / Gra / e_Rin / BAout / imm_sel - datapath strobes
//   ALU_op[3:0], BusDataSelect[4:0], GP_addr[3:0] - encoded selects
//   halted, instr_done, illegal_op            - sequencer status
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        con_out,
  output logic        incPC,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        e_OutPort,
  output logic        e_RA,
  output logic        e_CON_FF,
  output logic        ram_read,
  output logic        ram_write,
  output logic        MDR_read,
  output logic        Gra,
  output logic        e_Rin,
  output logic        BAout,
  output logic        imm_sel,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect,
  output logic [3:0]  GP_addr,
  output logic        halted,
  output logic        instr_done,
  output logic        illegal_op
);

  // E0..E5 must stay consecutive: the execute step advances by incrementing the state.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_F3   = 4'd4,
    S_E0   = 4'd5,
    S_E1   = 4'd6,
    S_E2   = 4'd7,
    S_E3   = 4'd8,
    S_E4   = 4'd9,
    S_E5   = 4'd10,
    S_HALT = 4'd11
  } state_t;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
`ifdef CU_MULDIV_EN
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
`endif
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [4:0] BUS_HI     = 5'd16;
  localparam logic [4:0] BUS_LO     = 5'd17;
  localparam logic [4:0] BUS_ZHIGH  = 5'd18;
  localparam logic [4:0] BUS_ZLOW   = 5'd19;
  localparam logic [4:0] BUS_PC     = 5'd20;
  localparam logic [4:0] BUS_MDR    = 5'd21;
  localparam logic [4:0] BUS_INPORT = 5'd22;

  localparam logic [3:0] ALU_ADD = 4'd0;

  state_t     state_q, state_d;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       unused_ir_bits;
  logic [2:0] step;
  logic       in_exec;
  logic [2:0] last_step;
  logic [3:0] alu_sel;

  assign op             = ir[31:27];
  assign ra             = ir[26:23];
  assign rb             = ir[22:19];
  assign rc             = ir[18:15];
  assign unused_ir_bits = ^ir[14:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    in_exec = 1'b1;
    step    = 3'd0;
    case (state_q)
      S_E0:    step = 3'd0;
      S_E1:    step = 3'd1;
      S_E2:    step = 3'd2;
      S_E3:    step = 3'd3;
      S_E4:    step = 3'd4;
      S_E5:    step = 3'd5;
      default: in_exec = 1'b0;
    endcase
  end

  // Index of the final execute step for each opcode; undefined ops finish in E0.
  always_comb begin
    last_step = 3'd0;
    case (op)
      OP_LD:                          last_step = 3'd5;
      OP_ST, OP_BR:                   last_step = 3'd3;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI:
                                      last_step = 3'd2;
      OP_NEG, OP_NOT, OP_JAL:         last_step = 3'd1;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                 last_step = 3'd3;
`endif
      default:                        last_step = 3'd0;
    endcase
  end

  always_comb begin
    alu_sel = ALU_ADD;
    case (op)
      OP_ADD, OP_ADDI: alu_sel = 4'd0;
      OP_SUB:          alu_sel = 4'd1;
      OP_AND, OP_ANDI: alu_sel = 4'd2;
      OP_OR, OP_ORI:   alu_sel = 4'd3;
      OP_ROR:          alu_sel = 4'd4;
      OP_ROL:          alu_sel = 4'd5;
      OP_SHR:          alu_sel = 4'd6;
      OP_SHRA:         alu_sel = 4'd7;
      OP_SHL:          alu_sel = 4'd8;
`ifdef CU_MULDIV_EN
      OP_MUL:          alu_sel = 4'd9;
      OP_DIV:          alu_sel = 4'd10;
`endif
      OP_NEG:          alu_sel = 4'd11;
      OP_NOT:          alu_sel = 4'd12;
      default:         alu_sel = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    incPC         = 1'b0;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    e_OutPort     = 1'b0;
    e_RA          = 1'b0;
    e_CON_FF      = 1'b0;
    ram_read      = 1'b0;
    ram_write     = 1'b0;
    MDR_read      = 1'b0;
    Gra           = 1'b0;
    e_Rin         = 1'b0;
    BAout         = 1'b0;
    imm_sel       = 1'b0;
    ALU_op        = 4'd0;
    BusDataSelect = 5'd0;
    GP_addr       = 4'd0;
    halted        = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_F0;
      S_F0: begin
        BusDataSelect = BUS_PC;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
        state_d       = S_F1;
      end
      S_F1: begin
        ram_read = 1'b1;
        state_d  = S_F2;
      end
      S_F2: begin
        ram_read = 1'b1;
        MDR_read = 1'b1;
        e_MDR    = 1'b1;
        state_d  = S_F3;
      end
      S_F3: begin
        BusDataSelect = BUS_MDR;
        e_IR          = 1'b1;
        state_d       = S_E0;
      end
      S_HALT: halted = 1'b1;
      default: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step)
              3'd0: begin BusDataSelect = {1'b0, rb}; e_Y = 1'b1; end
              3'd1: begin
                // Immediate forms take operand B from the IR constant instead of Rc.
                if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) imm_sel = 1'b1;
                else BusDataSelect = {1'b0, rc};
                ALU_op = alu_sel;
                e_Z    = 1'b1;
              end
              3'd2: begin BusDataSelect = BUS_ZLOW; Gra = 1'b1; e_Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (step)
              3'd0: begin BusDataSelect = {1'b0, rb}; ALU_op = alu_sel; e_Z = 1'b1; end
              3'd1: begin BusDataSelect = BUS_ZLOW; Gra = 1'b1; e_Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_LD, OP_LDI, OP_ST: begin
            case (step)
              // BAout makes R0 read as zero, so Rb=0 gives absolute addressing.
              3'd0: begin BusDataSelect = {1'b0, rb}; BAout = 1'b1; e_Y = 1'b1; end
              3'd1: begin imm_sel = 1'b1; ALU_op = ALU_ADD; e_Z = 1'b1; end
              3'd2: begin
                BusDataSelect = BUS_ZLOW;
                if (op == OP_LDI) begin Gra = 1'b1; e_Rin = 1'b1; end
                else e_MAR = 1'b1;
              end
              3'd3: begin
                if (op == OP_ST) begin BusDataSelect = {1'b0, ra}; ram_write = 1'b1; end
                else ram_read = 1'b1;
              end
              3'd4: begin ram_read = 1'b1; MDR_read = 1'b1; e_MDR = 1'b1; end
              3'd5: begin BusDataSelect = BUS_MDR; Gra = 1'b1; e_Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_BR: begin
            case (step)
              3'd0: begin BusDataSelect = {1'b0, ra}; e_RA = 1'b1; end
              3'd1: begin e_CON_FF = 1'b1; BusDataSelect = BUS_PC; e_Y = 1'b1; end
              3'd2: begin imm_sel = 1'b1; ALU_op = ALU_ADD; e_Z = 1'b1; end
              // Target is always computed; con_out only gates whether PC takes it.
              3'd3: begin BusDataSelect = BUS_ZLOW; e_PC = con_out; end
              default: ;
            endcase
          end
          OP_JR: begin BusDataSelect = {1'b0, ra}; e_PC = 1'b1; end
          OP_JAL: begin
            case (step)
              3'd0: begin BusDataSelect = BUS_PC; e_GP = 1'b1; GP_addr = 4'd15; end
              3'd1: begin BusDataSelect = {1'b0, ra}; e_PC = 1'b1; end
              default: ;
            endcase
          end
          OP_IN:   begin BusDataSelect = BUS_INPORT; Gra = 1'b1; e_Rin = 1'b1; end
          OP_OUT:  begin BusDataSelect = {1'b0, ra}; e_OutPort = 1'b1; end
          OP_MFHI: begin BusDataSelect = BUS_HI; Gra = 1'b1; e_Rin = 1'b1; end
          OP_MFLO: begin BusDataSelect = BUS_LO; Gra = 1'b1; e_Rin = 1'b1; end
          OP_NOP, OP_HALT: ;
`ifdef CU_MULDIV_EN
          OP_MUL, OP_DIV: begin
            case (step)
              3'd0: begin BusDataSelect = {1'b0, ra}; e_Y = 1'b1; end
              3'd1: begin BusDataSelect = {1'b0, rb}; ALU_op = alu_sel; e_Z = 1'b1; end
              3'd2: begin BusDataSelect = BUS_ZLOW; e_LO = 1'b1; end
              3'd3: begin BusDataSelect = BUS_ZHIGH; e_HI = 1'b1; end
              default: ;
            endcase
          end
`endif
          default: if (step == 3'd0) illegal_op = 1'b1;
        endcase

        if (in_exec) begin
          if (step == last_step) begin
            instr_done = 1'b1;
            if (op == OP_HALT) state_d = S_HALT;
            else if (run)      state_d = S_F0;
            else               state_d = S_IDLE;
          end else begin
            state_d = state_t'(state_q + 4'd1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  typedef struct packed {
    logic       incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
    logic       e_OutPort, e_RA, e_CON_FF, ram_read, ram_write, MDR_read;
    logic       Gra, e_Rin, BAout, imm_sel;
    logic [3:0] alu;
    logic [4:0] bus;
    logic [3:0] gp;
    logic       halted, instr_done, illegal_op;
  } outs_t;

  logic        clock, clear, run, con_out;
  logic [31:0] ir;
  logic        incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic        e_OutPort, e_RA, e_CON_FF, ram_read, ram_write, MDR_read;
  logic        Gra, e_Rin, BAout, imm_sel;
  logic [3:0]  ALU_op;
  logic [4:0]  BusDataSelect;
  logic [3:0]  GP_addr;
  logic        halted, instr_done, illegal_op;

  outs_t cur;
  outs_t snap [1:16];
  outs_t halt_exp;
  int    n_cmp, n_bad, cyc;

  control_unit dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .con_out(con_out),
    .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z),
    .e_HI(e_HI), .e_LO(e_LO), .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP),
    .e_OutPort(e_OutPort), .e_RA(e_RA), .e_CON_FF(e_CON_FF),
    .ram_read(ram_read), .ram_write(ram_write), .MDR_read(MDR_read),
    .Gra(Gra), .e_Rin(e_Rin), .BAout(BAout), .imm_sel(imm_sel),
    .ALU_op(ALU_op), .BusDataSelect(BusDataSelect), .GP_addr(GP_addr),
    .halted(halted), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  assign cur = '{incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
                 e_OutPort, e_RA, e_CON_FF, ram_read, ram_write, MDR_read,
                 Gra, e_Rin, BAout, imm_sel, ALU_op, BusDataSelect, GP_addr,
                 halted, instr_done, illegal_op};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  // Runs one instruction starting at the next edge (expected F0); cycles=0 on timeout.
  task automatic exec(input logic [31:0] instr, input bit drop_run, output int cycles);
    cycles = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock); #1;
      snap[k] = cur;
      if (k == 1) ir = instr;
      if (k == 2 && drop_run) run = 1'b0;
      if (cur.instr_done) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    clear = 1'b1; run = 1'b0; ir = 32'd0; con_out = 1'b0;
    halt_exp = '0;
    halt_exp.halted = 1'b1;
    #12;
    check("reset_outs", cur, 36'd0);
    @(negedge clock);
    clear = 1'b0;
    run   = 1'b1;

    exec(32'h18918000, 1'b0, cyc);
    check("add_f0_bus", snap[1].bus, 20);
    check("add_f0_mar", snap[1].e_MAR, 1);
    check("add_f0_incpc", snap[1].incPC, 1);
    check("add_e1_alu", snap[6].alu, 0);
    check("add_e1_bus", snap[6].bus, 3);
    check("add_e1_ez", snap[6].e_Z, 1);
    check("add_e2_bus", snap[7].bus, 19);
    check("add_e2_write", {snap[7].Gra, snap[7].e_Rin}, 2'b11);
    check("add_cycles", cyc, 7);

    exec(mk(5'd4, 4'd7, 4'd8, 4'd9), 1'b0, cyc);
    check("sub_e0_bus", snap[5].bus, 8);
    check("sub_e1_alu", snap[6].alu, 1);
    check("sub_e1_bus", snap[6].bus, 9);
    check("sub_cycles", cyc, 7);

    exec(mk(5'd13, 4'd1, 4'd2, 4'd0), 1'b0, cyc);
    check("andi_e1_imm", snap[6].imm_sel, 1);
    check("andi_e1_alu", snap[6].alu, 2);
    check("andi_cycles", cyc, 7);

    exec(mk(5'd0, 4'd5, 4'd6, 4'd0), 1'b0, cyc);
    check("ld_e0_baout", snap[5].BAout, 1);
    check("ld_e0_bus", snap[5].bus, 6);
    check("ld_e2_mar", snap[7].e_MAR, 1);
    check("ld_e3_read", snap[8].ram_read, 1);
    check("ld_e4_strobes", {snap[9].ram_read, snap[9].MDR_read, snap[9].e_MDR}, 3'b111);
    check("ld_e5_bus", snap[10].bus, 21);
    check("ld_e5_write", {snap[10].Gra, snap[10].e_Rin}, 2'b11);
    check("ld_cycles", cyc, 10);

    exec(mk(5'd2, 4'd3, 4'd4, 4'd0), 1'b0, cyc);
    check("st_e3_bus", snap[8].bus, 3);
    check("st_e3_write", snap[8].ram_write, 1);
    check("st_cycles", cyc, 8);

    con_out = 1'b0;
    exec(mk(5'd19, 4'd2, 4'd0, 4'd0), 1'b0, cyc);
    check("br0_e3_pc", snap[8].e_PC, 0);
    check("br0_e3_bus", snap[8].bus, 19);
    check("br0_cycles", cyc, 8);
    con_out = 1'b1;
    exec(mk(5'd19, 4'd2, 4'd0, 4'd0), 1'b0, cyc);
    check("br1_e1_conff", snap[6].e_CON_FF, 1);
    check("br1_e3_pc", snap[8].e_PC, 1);
    check("br1_e3_bus", snap[8].bus, 19);
    check("br1_cycles", cyc, 8);
    con_out = 1'b0;

    exec(mk(5'd21, 4'd4, 4'd0, 4'd0), 1'b0, cyc);
    check("jal_e0_gp", snap[5].e_GP, 1);
    check("jal_e0_gpaddr", snap[5].gp, 15);
    check("jal_e0_bus", snap[5].bus, 20);
    check("jal_e1_bus", snap[6].bus, 4);
    check("jal_e1_pc", snap[6].e_PC, 1);
    check("jal_cycles", cyc, 6);

    exec(mk(5'd17, 4'd1, 4'd2, 4'd0), 1'b0, cyc);
    check("neg_e0_alu", snap[5].alu, 11);
    check("neg_e0_bus", snap[5].bus, 2);
    check("neg_cycles", cyc, 6);

    exec(mk(5'd15, 4'd1, 4'd2, 4'd3), 1'b0, cyc);
`ifdef CU_MULDIV_EN
    check("mul_e1_alu", snap[6].alu, 9);
    check("mul_e2_lo", snap[7].e_LO, 1);
    check("mul_e3_bus", snap[8].bus, 18);
    check("mul_e3_hi", snap[8].e_HI, 1);
    check("mul_cycles", cyc, 8);
`else
    check("op15_illegal", snap[5].illegal_op, 1);
    check("op15_e0_quiet", snap[5].bus, 0);
    check("op15_cycles", cyc, 5);
`endif

    exec(mk(5'd29, 4'd0, 4'd0, 4'd0), 1'b0, cyc);
    check("op29_illegal", snap[5].illegal_op, 1);
    check("op29_cycles", cyc, 5);

    // run dropped mid-instruction: nop completes, then sequencer idles.
    exec(mk(5'd26, 4'd0, 4'd0, 4'd0), 1'b1, cyc);
    check("nop_cycles", cyc, 5);
    @(posedge clock); #1;
    check("idle_after_drop", cur, 36'd0);
    @(posedge clock); #1;
    check("idle_stays", cur, 36'd0);

    run = 1'b1;
    exec(mk(5'd27, 4'd0, 4'd0, 4'd0), 1'b0, cyc);
    check("halt_cycles", cyc, 5);
    check("halt_e0_done", snap[5].instr_done, 1);
    check("halt_e0_not_halted", snap[5].halted, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      check("halt_hold", cur, halt_exp);
    end

    @(negedge clock);
    clear = 1'b1;
    #1;
    check("clear_from_halt", cur, 36'd0);
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock); #1;
    check("f0_after_clear_mar", cur.e_MAR, 1);
    check("f0_after_clear_bus", cur.bus, 20);

    ir = mk(5'd0, 4'd5, 4'd6, 4'd0);
    repeat (7) @(posedge clock);
    #1;
    check("ld2_e3_read", cur.ram_read, 1);
    #2;
    clear = 1'b1;
    #1;
    check("clear_mid_ld", cur, 36'd0);
    #2;
    clear = 1'b0;
    run   = 1'b0;
    @(posedge clock); #1;
    check("idle_after_abort", cur, 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Mini SRC control sequencer. Fetches each instruction from RAM into IR through MAR/MDR, decodes opcode and register fields, and then drives every datapath enable, bus select, ALU opcode and RAM strobe, one step per clock. It sits beside the datapath and is its only source of control signals; datapath status comes back as `ir` and `con_out`.

## Interface
- No parameters. Bus and ALU encodings are fixed, as listed under Operation.
- `clock` in 1: rising-edge clock.
- `clear` in 1: asynchronous, active-high reset.
- `run` in 1: level signal that permits instruction fetch.
- `ir` in 32: IR contents. Fields: op=[31:27], Ra=[26:23], Rb=[22:19], Rc=[18:15].
- `con_out` in 1: CON FF result.
- Outputs, 1 bit each: `incPC e_PC e_IR e_Y e_Z e_HI e_LO e_MDR e_MAR e_GP e_OutPort e_RA e_CON_FF ram_read ram_write MDR_read Gra e_Rin BAout imm_sel`.
- `ALU_op` out 4: ALU operation code.
- `BusDataSelect` out 5: bus source select.
- `GP_addr` out 4: register index for direct GP writes.
- `halted` out 1: high in HALT state.
- `instr_done` out 1: one-cycle pulse on the last step of each instruction.
- `illegal_op` out 1: one-cycle pulse in E0 for an undefined opcode.

## Operation
- Encodings:
  - Bus sources: 0–15 = R0–R15, 16 = HI, 17 = LO, 18 = Zhigh, 19 = Zlow, 20 = PC, 21 = MDR, 22 = InPort.
  - ALU_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ROR, 5 ROL, 6 SHR, 7 SHRA, 8 SHL, 9 MUL, 10 DIV, 11 NEG, 12 NOT.
- States: IDLE, F0–F3, E0–E5, HALT. Every output not named in a step is 0.
- Outputs are a combinational decode of (state, `ir`, `con_out`).
- "Write Ra" means Gra=1 and e_Rin=1.
- "bus=Rx" means BusDataSelect={0,field}.
- Fetch:
  - F0: bus=PC, e_MAR, incPC.
  - F1: ram_read.
  - F2: ram_read, MDR_read, e_MDR.
  - F3: bus=MDR, e_IR.
- Execute (step E0 onward):
  - add/sub/and/or/ror/rol/shr/shra/shl (op 3–11): E0 bus=Rb, e_Y; E1 bus=Rc, ALU_op, e_Z; E2 bus=Zlow, write Ra.
  - addi/andi/ori (12–14): E0 bus=Rb, e_Y; E1 imm_sel, ALU_op, e_Z; E2 bus=Zlow, write Ra.
  - neg/not (17/18): E0 bus=Rb, ALU_op, e_Z; E1 bus=Zlow, write Ra.
  - ld (0): E0 bus=Rb, BAout, e_Y; E1 imm_sel, ADD, e_Z; E2 bus=Zlow, e_MAR; E3 ram_read; E4 ram_read, MDR_read, e_MDR; E5 bus=MDR, write Ra.
  - ldi (1): E0–E1 as ld; E2 bus=Zlow, write Ra.
  - st (2): E0–E2 as ld; E3 bus=Ra, ram_write.
  - br (19): E0 bus=Ra, e_RA; E1 e_CON_FF, bus=PC, e_Y; E2 imm_sel, ADD, e_Z; E3 bus=Zlow, with e_PC=`con_out`.
  - jr (20): E0 bus=Ra, e_PC.
  - jal (21): E0 bus=PC, e_GP, GP_addr=15; E1 bus=Ra, e_PC.
  - in (22): E0 bus=InPort, write Ra.
  - out (23): E0 bus=Ra, e_OutPort.
  - mfhi (24): E0 bus=HI, write Ra.
  - mflo (25): E0 bus=LO, write Ra.
  - nop (26): E0 only, no enables.
  - halt (27): E0, then HALT.
  - Undefined opcodes: E0 with no enables and `illegal_op`=1, then behave as nop.
- Transitions:
  - IDLE→F0 when `run`=1.
  - F0→F1→F2→F3→E0 unconditionally.
  - The last E step goes to F0 if `run`=1, otherwise IDLE.
  - HALT is absorbing; only `clear` exits it.
- `run` is sampled only in IDLE and on the last E step. Dropping `run` mid-instruction completes the current instruction.

## Timing
- Reset: state=IDLE; every output 0, including `halted`, `instr_done`, `illegal_op`, ALU_op=0, BusDataSelect=0, GP_addr=0.
- `clear` mid-instruction forces IDLE asynchronously and deasserts all enables immediately; the partial instruction is abandoned.
- Each step lasts exactly one clock. Enables are captured by the datapath at the rising edge that ends the step.
- Total cycles per instruction, including the 4-cycle fetch:
  - R-type and immediate: 7.
  - neg/not: 6.
  - ld: 10.
  - ldi: 7.
  - st: 8.
  - br: 8, whether taken or not.
  - jal: 6.
  - jr/in/out/mf/nop: 5.
  - mul/div: 8.
- F0 incPC: MAR captures the pre-increment PC at the same edge the PC increments.
- br E3: `con_out` must be stable from the E1 edge onward; only the E3 value is used.
- `instr_done` is high during the final E step. For halt it is high in E0, and `halted` rises at the next edge.

## Configuration
- `CU_MULDIV_EN` defined: mul (15) and div (16) are legal.
  - E0 bus=Ra, e_Y.
  - E1 bus=Rb, ALU_op=9 (mul) or 10 (div), e_Z.
  - E2 bus=Zlow, e_LO.
  - E3 bus=Zhigh, e_HI.
- `CU_MULDIV_EN` undefined: ops 15/16 are undefined opcodes (`illegal_op` pulse, nop timing). No mul/div decode logic is present.

## Test plan
- Reset, then `run`=1 with add (ir=0x18918000: Ra=1, Rb=2, Rc=3) → F0 BusDataSelect=20, e_MAR=1, incPC=1; E1 ALU_op=0, BusDataSelect=3, e_Z=1; E2 BusDataSelect=19, Gra=1, e_Rin=1; `instr_done` high in cycle 7.
- ld, op 0 → E0 BAout=1; E3 and E4 ram_read=1; E4 MDR_read=1 and e_MDR=1; E5 BusDataSelect=21 with Ra write; 10 cycles total.
- br with `con_out`=0, then again with `con_out`=1 → E3 e_PC=0, then E3 e_PC=1 with BusDataSelect=19; both take 8 cycles.
- jal Ra=4 → E0 e_GP=1, GP_addr=15, BusDataSelect=20; E1 BusDataSelect=4, e_PC=1.
- halt, then hold `run`=1 for 20 cycles → `halted`=1 and all enables stay 0. Pulse `clear` → IDLE; with `run`=1 the next cycle is F0.
- op 15 → with `CU_MULDIV_EN`: E2 e_LO=1, E3 BusDataSelect=18 and e_HI=1. Without it: `illegal_op` pulses in E0 and the next fetch starts after 5 cycles. Separately, assert `clear` during ld E3 → all outputs 0 the same cycle.
